// File: rtl/canny_gradient_pack_if.sv
`default_nettype none
// ============================================================================
// canny_gradient_pack_if : Sobel-side pixel stream in, packed gradient out
// Rev 1.0
// ============================================================================
interface canny_gradient_pack_if #(
  parameter int GRAD_WIDTH = 11
);
  logic                  sobel_vs;
  logic                  sobel_hs;
  logic                  sobel_de;
  logic [GRAD_WIDTH-1:0] gx;
  logic [GRAD_WIDTH-1:0] gy;
  logic                  grandient_vs;
  logic                  grandient_hs;
  logic                  grandient_de;
  logic [15:0]           gra_path;

  modport master (
    output sobel_vs, sobel_hs, sobel_de, gx, gy,
    input  grandient_vs, grandient_hs, grandient_de, gra_path
  );

  modport slave (
    input  sobel_vs, sobel_hs, sobel_de, gx, gy,
    output grandient_vs, grandient_hs, grandient_de, gra_path
  );
endinterface
`default_nettype wire

// File: rtl/canny_gradient_pack.sv
`default_nettype none
// ============================================================================
// canny_gradient_pack : Gx/Gy -> {thr_code, dir_onehot, magnitude}, 3-cycle
// pipeline with aligned sync and per-frame strong/weak pixel counts. Rev 1.0
// ============================================================================
module canny_gradient_pack #(
  parameter int         GRAD_WIDTH   = 11,
  parameter int         CNT_WIDTH    = 20,
  parameter logic [9:0] THR_HIGH_DEF = 10'd200,
  parameter logic [9:0] THR_LOW_DEF  = 10'd80
) (
  input  logic                    clk,
  input  logic                    rst_s,
  canny_gradient_pack_if.slave    pix,
  input  logic [9:0]              thr_high,
  input  logic [9:0]              thr_low,
  output logic [CNT_WIDTH-1:0]    frm_strong_cnt,
  output logic [CNT_WIDTH-1:0]    frm_weak_cnt,
  output logic                    frm_cnt_valid
);
  localparam int                 SUM_W      = GRAD_WIDTH + 1;
  localparam int                 PROD_W     = 20;
  localparam logic [PROD_W-1:0]  TAN_K      = 20'd106;
  localparam logic [9:0]         MAG_MAX    = 10'd1023;
  localparam logic [3:0]         DIR_NONE   = 4'b0000;
  localparam logic [3:0]         DIR_H      = 4'b0001;
  localparam logic [3:0]         DIR_V      = 4'b0100;
  localparam logic [3:0]         DIR_D_MAIN = 4'b1000;
  localparam logic [3:0]         DIR_D_ANTI = 4'b0010;
  localparam logic [1:0]         CODE_STR   = 2'b11;
  localparam logic [1:0]         CODE_WEAK  = 2'b01;
  localparam logic [1:0]         CODE_NONE  = 2'b00;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // sync vectors are {vs, hs, de}
  logic [GRAD_WIDTH-1:0] w_ax, w_ay, r_ax, r_ay;
  logic                  r_sgn;
  logic [2:0]            r_sync1, r_sync2, r_sync3;
  logic [SUM_W-1:0]      w_sum;
  logic [9:0]            w_mag, r_mag;
  logic [PROD_W-1:0]     w_ay_sh, w_ax_sh, w_ax_k, w_ay_k;
  logic [3:0]            w_dir, r_dir;
  logic [1:0]            w_code;
  logic [15:0]           r_path;
  logic [9:0]            r_hi, r_lo;
  logic                  r_vs_in_d, r_vs_out_d;
  logic                  w_vs_in_rise, w_vs_out_rise;
  logic                  w_inc_s, w_inc_w;
  logic [CNT_WIDTH-1:0]  r_run_s, r_run_w;

  // S1: magnitudes of the two's-complement gradients; -2^(N-1) maps to 2^(N-1)
  always_comb begin
    w_ax = pix.gx[GRAD_WIDTH-1] ? (~pix.gx + 1'b1) : pix.gx;
    w_ay = pix.gy[GRAD_WIDTH-1] ? (~pix.gy + 1'b1) : pix.gy;
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      r_ax    <= '0;
      r_ay    <= '0;
      r_sgn   <= 1'b0;
      r_sync1 <= '0;
    end else begin
      r_ax    <= w_ax;
      r_ay    <= w_ay;
      r_sgn   <= pix.gx[GRAD_WIDTH-1] ^ pix.gy[GRAD_WIDTH-1];
      r_sync1 <= {pix.sobel_vs, pix.sobel_hs, pix.sobel_de};
    end
  end

  // S2: L1 magnitude and 4-way direction via tan(22.5) ~= 106/256
  always_comb begin
    w_sum   = {1'b0, r_ax} + {1'b0, r_ay};
    w_mag   = (w_sum > SUM_W'(MAG_MAX)) ? MAG_MAX : w_sum[9:0];
    w_ay_sh = PROD_W'(r_ay) << 8;
    w_ax_sh = PROD_W'(r_ax) << 8;
    w_ax_k  = PROD_W'(r_ax) * TAN_K;
    w_ay_k  = PROD_W'(r_ay) * TAN_K;
    w_dir   = DIR_NONE;
    if (r_ax == '0 && r_ay == '0)  w_dir = DIR_NONE;
    else if (w_ay_sh <= w_ax_k)    w_dir = DIR_H;
    else if (w_ay_k >= w_ax_sh)    w_dir = DIR_V;
    else if (!r_sgn)               w_dir = DIR_D_MAIN;
    else                           w_dir = DIR_D_ANTI;
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      r_mag   <= '0;
      r_dir   <= '0;
      r_sync2 <= '0;
    end else begin
      r_mag   <= w_mag;
      r_dir   <= w_dir;
      r_sync2 <= r_sync1;
    end
  end

  // S3: threshold classification against the thresholds latched at frame start
  always_comb begin
    if (r_mag >= r_hi)      w_code = CODE_STR;
    else if (r_mag >= r_lo) w_code = CODE_WEAK;
    else                    w_code = CODE_NONE;
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      r_path  <= '0;
      r_sync3 <= '0;
    end else begin
      r_path  <= r_sync2[0] ? {w_code, r_dir, r_mag} : 16'h0000;
      r_sync3 <= r_sync2;
    end
  end

  assign w_vs_in_rise = pix.sobel_vs & ~r_vs_in_d;

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      r_vs_in_d <= 1'b0;
      r_hi      <= THR_HIGH_DEF;
      r_lo      <= THR_LOW_DEF;
    end else begin
      r_vs_in_d <= pix.sobel_vs;
      if (w_vs_in_rise) begin
        r_hi <= thr_high;
        r_lo <= (thr_low < thr_high) ? thr_low : thr_high;
      end
    end
  end

  // Per-frame statistics follow the delayed frame sync so they match the output stream
  assign w_vs_out_rise = r_sync3[2] & ~r_vs_out_d;
  assign w_inc_s       = r_sync3[0] & (r_path[15:14] == CODE_STR);
  assign w_inc_w       = r_sync3[0] & (r_path[15:14] == CODE_WEAK);

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      r_vs_out_d     <= 1'b0;
      r_run_s        <= '0;
      r_run_w        <= '0;
      frm_strong_cnt <= '0;
      frm_weak_cnt   <= '0;
      frm_cnt_valid  <= 1'b0;
    end else begin
      r_vs_out_d    <= r_sync3[2];
      frm_cnt_valid <= w_vs_out_rise;
      if (w_vs_out_rise) begin
        frm_strong_cnt <= r_run_s;
        frm_weak_cnt   <= r_run_w;
        r_run_s        <= CNT_WIDTH'(w_inc_s);
        r_run_w        <= CNT_WIDTH'(w_inc_w);
      end else begin
        if (w_inc_s && r_run_s != CNT_MAX) r_run_s <= r_run_s + 1'b1;
        if (w_inc_w && r_run_w != CNT_MAX) r_run_w <= r_run_w + 1'b1;
      end
    end
  end

  assign pix.grandient_vs = r_sync3[2];
  assign pix.grandient_hs = r_sync3[1];
  assign pix.grandient_de = r_sync3[0];
  assign pix.gra_path     = r_path;
endmodule
`default_nettype wire
